// File: rtl/game_timer_ctrl.sv
// Whack-a-mole round sequencer: idle, ready countdown, play countdown, pause, game over.
// Optional TIMER_BONUS_EN adds a saturating bonus-seconds input in PLAY.
module game_timer_ctrl #(
    parameter int GAME_SECONDS  = 30,
    parameter int READY_SECONDS = 3,
    parameter int SEC_W         = 6
`ifdef TIMER_BONUS_EN
    ,
    parameter int BONUS_SECONDS = 5
`endif
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clk_1Hz,
    input  logic             start,
    input  logic             pause,
`ifdef TIMER_BONUS_EN
    input  logic             bonus_add,
`endif
    output logic [2:0]       state,
    output logic [SEC_W-1:0] seconds_left,
    output logic [1:0]       ready_count,
    output logic             game_active,
    output logic             game_over,
    output logic             sec_tick,
    output logic             done_pulse
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [SEC_W-1:0] SEC_RELOAD = SEC_W'(GAME_SECONDS);
    localparam logic [1:0]       RDY_RELOAD = 2'(READY_SECONDS);
    localparam state_t           ST_START   = (READY_SECONDS == 0) ? ST_PLAY : ST_READY;
`ifdef TIMER_BONUS_EN
    localparam int               SEC_MAX    = (2 ** SEC_W) - 1;
`endif

    state_t           state_q, state_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [1:0]       rdy_q, rdy_d;
    logic             hz_prev_q, start_prev_q;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             active_q, over_q;
    logic             tick, start_e;

    // clk_1Hz is only ever sampled as data; both histories reset high so a
    // level already high at reset release never looks like an edge.
    assign tick    = clk_1Hz & ~hz_prev_q;
    assign start_e = start & ~start_prev_q;

`ifdef TIMER_BONUS_EN
    int bonus_sum;
`endif

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        rdy_d   = rdy_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
`ifdef TIMER_BONUS_EN
        bonus_sum = int'(sec_q) - int'(tick) + BONUS_SECONDS;
`endif
        case (state_q)
            ST_IDLE: begin
                sec_d = SEC_RELOAD;
                rdy_d = RDY_RELOAD;
                if (start_e) state_d = ST_START;
            end
            ST_READY: begin
                if (tick) begin
                    tick_d = 1'b1;
                    if (rdy_q <= 2'd1) begin
                        rdy_d   = 2'd0;
                        state_d = ST_PLAY;
                    end else begin
                        rdy_d = rdy_q - 2'd1;
                    end
                end
            end
            ST_PLAY: begin
                tick_d = tick;
`ifdef TIMER_BONUS_EN
                if (bonus_add) begin
                    sec_d = (bonus_sum > SEC_MAX) ? SEC_W'(SEC_MAX) : SEC_W'(bonus_sum);
                    if (pause) state_d = ST_PAUSE;
                end else
`endif
                if (tick && sec_q <= SEC_W'(1)) begin
                    // expiry outranks a simultaneous pause request
                    sec_d   = '0;
                    state_d = ST_OVER;
                    done_d  = 1'b1;
                end else begin
                    if (tick) sec_d = sec_q - SEC_W'(1);
                    if (pause) state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (!pause) state_d = ST_PLAY;
            end
            ST_OVER: begin
                sec_d = '0;
                if (start_e) begin
                    sec_d   = SEC_RELOAD;
                    rdy_d   = RDY_RELOAD;
                    state_d = ST_START;
                end
            end
            default: begin
                sec_d   = SEC_RELOAD;
                rdy_d   = RDY_RELOAD;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sec_q        <= SEC_RELOAD;
            rdy_q        <= RDY_RELOAD;
            hz_prev_q    <= 1'b1;
            start_prev_q <= 1'b1;
            tick_q       <= 1'b0;
            done_q       <= 1'b0;
            active_q     <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sec_q        <= sec_d;
            rdy_q        <= rdy_d;
            hz_prev_q    <= clk_1Hz;
            start_prev_q <= start;
            tick_q       <= tick_d;
            done_q       <= done_d;
            active_q     <= (state_d == ST_PLAY);
            over_q       <= (state_d == ST_OVER);
        end
    end

    assign state        = state_q;
    assign seconds_left = sec_q;
    assign ready_count  = rdy_q;
    assign game_active  = active_q;
    assign game_over    = over_q;
    assign sec_tick     = tick_q;
    assign done_pulse   = done_q;

endmodule
